// File: rtl/aes_inv_core_if.sv
// Handshake and data bundle between the SPI front end and the AES-128
// decrypt core. The front end is the master; the core is the slave.
interface aes_inv_core_if;
   logic         start;
   logic [127:0] key;
   logic [127:0] cyphertext;
   logic         busy;
   logic         done;
   logic [127:0] plaintext;

   modport master (output start, key, cyphertext, input busy, done, plaintext);
   modport slave  (input start, key, cyphertext, output busy, done, plaintext);
endinterface

// File: rtl/aes_inv_core.sv
// Iterative AES-128 inverse cipher. The cipher key is first expanded
// forward to round key 10, then the state is decrypted one round per cycle
// while the key schedule is walked backwards. An optional one-entry cache
// keeps the last key and its rk10 so that repeated keys skip the expansion.
// Byte packing: [127:120] = S0,0, column-major; w0 = [127:96].
module aes_inv_core #(
   parameter int RK10_CACHE = 1
) (
   input  logic          clk,
   input  logic          reset,
   aes_inv_core_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DECRYPT, S_DONE} state_t;

   // ---------------------------------------------------------------- GF(2^8)
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      return gf_mul(gf_mul(x240, x12), x2);
   endfunction

   // S-boxes are computed arithmetically (inverse + affine map) so the core
   // carries no table file.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] mul_9(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [7:0] mul_b(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic logic [7:0] mul_d(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic logic [7:0] mul_e(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction

   function automatic logic [7:0] inv_mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                                input logic [7:0] a2, input logic [7:0] a3);
      return mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------- state
   state_t       state_reg;
   logic [127:0] key_reg;
   logic [127:0] ct_reg;
   logic [127:0] st_reg;
   logic [3:0]   rnd_reg;
   logic [3:0]   dcnt_reg;
   logic         busy_reg;
   logic         done_reg;
   logic [127:0] cache_key_reg;
   logic [127:0] cache_rk10_reg;
   logic         cache_valid_reg;

   // ---------------------------------------------------------------- key schedule
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sw_in, sw_rot, sw_out, rc_word;
   logic [31:0]  f0, f1, f2, f3;
   logic [3:0]   rc_idx;
   logic [127:0] fwd_key, inv_key;
   logic         cache_hit;

   assign {w0, w1, w2, w3} = key_reg;

   // One SubWord serves both directions: w3 going forward, w3^w2 going back.
   assign rc_idx  = (state_reg == S_EXPAND) ? rnd_reg : (4'd10 - dcnt_reg);
   assign rc_word = {rcon(rc_idx), 24'h000000};
   assign sw_in   = (state_reg == S_EXPAND) ? w3 : (w3 ^ w2);
   assign sw_rot  = {sw_in[23:0], sw_in[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_subword
         assign sw_out[31-8*gi -: 8] = sbox_fwd(sw_rot[31-8*gi -: 8]);
      end
   endgenerate

   assign f0      = w0 ^ sw_out ^ rc_word;
   assign f1      = w1 ^ f0;
   assign f2      = w2 ^ f1;
   assign f3      = w3 ^ f2;
   assign fwd_key = {f0, f1, f2, f3};
   assign inv_key = {w0 ^ sw_out ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

   assign cache_hit = (RK10_CACHE != 0) && cache_valid_reg && (bus.key == cache_key_reg);

   // ---------------------------------------------------------------- round datapath
   logic [127:0] isr, isb, ark, imc;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         localparam int R   = gi % 4;
         localparam int C   = gi / 4;
         localparam int SRC = 4 * ((C - R + 4) % 4) + R;
         // Row R rotates right by R: output column C takes input column C-R.
         assign isr[127-8*gi -: 8] = st_reg[127-8*SRC -: 8];
         assign isb[127-8*gi -: 8] = sbox_inv(isr[127-8*gi -: 8]);
      end
   endgenerate

   assign ark = isb ^ key_reg;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_col
         logic [7:0] a0, a1, a2, a3;
         assign a0 = ark[127-32*gi -: 8];
         assign a1 = ark[119-32*gi -: 8];
         assign a2 = ark[111-32*gi -: 8];
         assign a3 = ark[103-32*gi -: 8];
         assign imc[127-32*gi -: 8] = inv_mix_byte(a0, a1, a2, a3);
         assign imc[119-32*gi -: 8] = inv_mix_byte(a1, a2, a3, a0);
         assign imc[111-32*gi -: 8] = inv_mix_byte(a2, a3, a0, a1);
         assign imc[103-32*gi -: 8] = inv_mix_byte(a3, a0, a1, a2);
      end
   endgenerate

   // Control FSM plus all datapath, key and cache registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_IDLE;
         key_reg         <= '0;
         ct_reg          <= '0;
         st_reg          <= '0;
         rnd_reg         <= '0;
         dcnt_reg        <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         cache_key_reg   <= '0;
         cache_rk10_reg  <= '0;
         cache_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  ct_reg   <= bus.cyphertext;
                  rnd_reg  <= 4'd1;
                  dcnt_reg <= 4'd0;
                  busy_reg <= 1'b1;
                  done_reg <= 1'b0;
                  if (cache_hit) begin
                     key_reg   <= cache_rk10_reg;
                     state_reg <= S_DECRYPT;
                  end else begin
                     key_reg   <= bus.key;
                     state_reg <= S_EXPAND;
                     // Entry is invalid until its rk10 has been produced.
                     if (RK10_CACHE != 0) begin
                        cache_key_reg   <= bus.key;
                        cache_valid_reg <= 1'b0;
                     end
                  end
               end
            end
            S_EXPAND: begin
               key_reg <= fwd_key;
               rnd_reg <= rnd_reg + 4'd1;
               if (rnd_reg == 4'd10) begin
                  state_reg <= S_DECRYPT;
                  dcnt_reg  <= 4'd0;
                  if (RK10_CACHE != 0) begin
                     cache_rk10_reg  <= fwd_key;
                     cache_valid_reg <= 1'b1;
                  end
               end
            end
            S_DECRYPT: begin
               dcnt_reg <= dcnt_reg + 4'd1;
               if (dcnt_reg == 4'd0) begin
                  st_reg  <= ct_reg ^ key_reg;
                  key_reg <= inv_key;
               end else if (dcnt_reg == 4'd10) begin
                  st_reg    <= ark;
                  state_reg <= S_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end else begin
                  st_reg  <= imc;
                  key_reg <= inv_key;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.plaintext = st_reg;

endmodule
